// File: rtl/riscv_pkg.sv
// Shared types for the ID/EX stage: ALU opcodes, result-source and forward-select encodings,
// plus the registered control bundle carried from ID into EX.
package riscv_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_SUB  = 4'h1,
      ALU_AND  = 4'h2,
      ALU_OR   = 4'h3,
      ALU_XOR  = 4'h4,
      ALU_SLT  = 4'h5,
      ALU_SLTU = 4'h6,
      ALU_SLL  = 4'h7,
      ALU_SRL  = 4'h8,
      ALU_SGE  = 4'h9,
      ALU_SGEU = 4'hA,
      ALU_SRA  = 4'hB
   } alu_op_e;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10
   } result_src_e;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        alu_src;
      result_src_e result_src;
      alu_op_e     alu_ctrl;
   } ex_ctrl_t;

   localparam ex_ctrl_t CTRL_BUBBLE = '{
      valid:      1'b0,
      reg_write:  1'b0,
      mem_write:  1'b0,
      branch:     1'b0,
      jump:       1'b0,
      alu_src:    1'b0,
      result_src: RES_ALU,
      alu_ctrl:   ALU_ADD
   };

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Combinational bypass selector for one EX source operand; MEM beats WB, x0 and
// invalid EX slots never forward.
module forward_unit
   import riscv_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              valid_i,
   input  logic [REG_AW-1:0] rs_i,
   input  logic              reg_write_m_i,
   input  logic [REG_AW-1:0] rd_m_i,
   input  logic              reg_write_w_i,
   input  logic [REG_AW-1:0] rd_w_i,
   output fwd_sel_e          fwd_o
);

   logic hit_m;
   logic hit_w;

   assign hit_m = reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i);
   assign hit_w = reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i);

   always_comb begin
      fwd_o = FWD_REG;
      if (!valid_i) begin
         fwd_o = FWD_REG;
      end else if (hit_m) begin
         fwd_o = FWD_MEM;
      end else if (hit_w) begin
         fwd_o = FWD_WB;
      end else begin
         fwd_o = FWD_REG;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand bypass and load-use detection.
// Optional EX_BUBBLE_CNT_EN adds a free-running count of bubbles entering EX.
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_AW     = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  EnE,
   input  logic                  FlushE,
   input  logic                  ValidD,
   input  logic [DATA_WIDTH-1:0] RD1D,
   input  logic [DATA_WIDTH-1:0] RD2D,
   input  logic [DATA_WIDTH-1:0] PCD,
   input  logic [DATA_WIDTH-1:0] PCPlus4D,
   input  logic [DATA_WIDTH-1:0] ImmExtD,
   input  logic [REG_AW-1:0]     Rs1D,
   input  logic [REG_AW-1:0]     Rs2D,
   input  logic [REG_AW-1:0]     RdD,
   input  logic [3:0]            ALUControlD,
   input  logic                  ALUSrcD,
   input  logic                  RegWriteD,
   input  logic                  MemWriteD,
   input  logic                  BranchD,
   input  logic                  JumpD,
   input  logic [1:0]            ResultSrcD,
   input  logic [DATA_WIDTH-1:0] ALUResultM,
   input  logic [REG_AW-1:0]     RdM,
   input  logic                  RegWriteM,
   input  logic [DATA_WIDTH-1:0] ResultW,
   input  logic [REG_AW-1:0]     RdW,
   input  logic                  RegWriteW,
   output logic [DATA_WIDTH-1:0] SrcAE,
   output logic [DATA_WIDTH-1:0] SrcBE,
   output logic [DATA_WIDTH-1:0] WriteDataE,
   output logic [3:0]            ALUControlE,
   output logic [DATA_WIDTH-1:0] PCE,
   output logic [DATA_WIDTH-1:0] PCPlus4E,
   output logic [DATA_WIDTH-1:0] ImmExtE,
   output logic [REG_AW-1:0]     RdE,
   output logic [REG_AW-1:0]     Rs1E,
   output logic [REG_AW-1:0]     Rs2E,
   output logic                  RegWriteE,
   output logic                  MemWriteE,
   output logic                  BranchE,
   output logic                  JumpE,
   output logic [1:0]            ResultSrcE,
   output logic                  ValidE,
   output logic [1:0]            ForwardAE,
   output logic [1:0]            ForwardBE,
   output logic                  LoadUseD
`ifdef EX_BUBBLE_CNT_EN
   ,
   output logic [31:0]           BubbleCntE
`endif
);

   ex_ctrl_t              ctrl_q, ctrl_d;
   logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d, pc4_q, pc4_d, imm_q, imm_d;
   logic [REG_AW-1:0]     rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic                  bubble_in;
   fwd_sel_e              fwd_a, fwd_b;
   logic [DATA_WIDTH-1:0] fwd_a_val, fwd_b_val;

   // Flush beats stall; a load with no valid ID instruction also enters EX as a bubble.
   always_comb begin
      ctrl_d    = ctrl_q;
      rd1_d     = rd1_q;
      rd2_d     = rd2_q;
      pc_d      = pc_q;
      pc4_d     = pc4_q;
      imm_d     = imm_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      rd_d      = rd_q;
      bubble_in = 1'b0;
      if (FlushE) begin
         ctrl_d    = CTRL_BUBBLE;
         rd1_d     = '0;
         rd2_d     = '0;
         pc_d      = '0;
         pc4_d     = '0;
         imm_d     = '0;
         rs1_d     = '0;
         rs2_d     = '0;
         rd_d      = '0;
         bubble_in = 1'b1;
      end else if (EnE) begin
         ctrl_d.valid      = ValidD;
         ctrl_d.reg_write  = RegWriteD;
         ctrl_d.mem_write  = MemWriteD;
         ctrl_d.branch     = BranchD;
         ctrl_d.jump       = JumpD;
         ctrl_d.alu_src    = ALUSrcD;
         ctrl_d.result_src = result_src_e'(ResultSrcD);
         ctrl_d.alu_ctrl   = alu_op_e'(ALUControlD);
         rd1_d     = RD1D;
         rd2_d     = RD2D;
         pc_d      = PCD;
         pc4_d     = PCPlus4D;
         imm_d     = ImmExtD;
         rs1_d     = Rs1D;
         rs2_d     = Rs2D;
         rd_d      = RdD;
         bubble_in = !ValidD;
      end else begin
         bubble_in = 1'b0;
      end
   end

   // ID/EX register bank.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl_q <= CTRL_BUBBLE;
         rd1_q  <= '0;
         rd2_q  <= '0;
         pc_q   <= '0;
         pc4_q  <= '0;
         imm_q  <= '0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         rd_q   <= '0;
      end else begin
         ctrl_q <= ctrl_d;
         rd1_q  <= rd1_d;
         rd2_q  <= rd2_d;
         pc_q   <= pc_d;
         pc4_q  <= pc4_d;
         imm_q  <= imm_d;
         rs1_q  <= rs1_d;
         rs2_q  <= rs2_d;
         rd_q   <= rd_d;
      end
   end

   forward_unit #(.REG_AW(REG_AW)) u_fwd_a (
      .valid_i       (ctrl_q.valid),
      .rs_i          (rs1_q),
      .reg_write_m_i (RegWriteM),
      .rd_m_i        (RdM),
      .reg_write_w_i (RegWriteW),
      .rd_w_i        (RdW),
      .fwd_o         (fwd_a)
   );

   forward_unit #(.REG_AW(REG_AW)) u_fwd_b (
      .valid_i       (ctrl_q.valid),
      .rs_i          (rs2_q),
      .reg_write_m_i (RegWriteM),
      .rd_m_i        (RdM),
      .reg_write_w_i (RegWriteW),
      .rd_w_i        (RdW),
      .fwd_o         (fwd_b)
   );

   // Operand bypass muxes; the unused select code falls back to the register value.
   always_comb begin
      fwd_a_val = rd1_q;
      fwd_b_val = rd2_q;
      case (fwd_a)
         FWD_MEM: fwd_a_val = ALUResultM;
         FWD_WB:  fwd_a_val = ResultW;
         default: fwd_a_val = rd1_q;
      endcase
      case (fwd_b)
         FWD_MEM: fwd_b_val = ALUResultM;
         FWD_WB:  fwd_b_val = ResultW;
         default: fwd_b_val = rd2_q;
      endcase
   end

   assign SrcAE       = fwd_a_val;
   assign SrcBE       = ctrl_q.alu_src ? imm_q : fwd_b_val;
   assign WriteDataE  = fwd_b_val;
   assign ForwardAE   = fwd_a;
   assign ForwardBE   = fwd_b;
   assign ALUControlE = ctrl_q.alu_ctrl;
   assign PCE         = pc_q;
   assign PCPlus4E    = pc4_q;
   assign ImmExtE     = imm_q;
   assign RdE         = rd_q;
   assign Rs1E        = rs1_q;
   assign Rs2E        = rs2_q;
   assign RegWriteE   = ctrl_q.reg_write;
   assign MemWriteE   = ctrl_q.mem_write;
   assign BranchE     = ctrl_q.branch;
   assign JumpE       = ctrl_q.jump;
   assign ResultSrcE  = ctrl_q.result_src;
   assign ValidE      = ctrl_q.valid;

   // Deliberately unqualified by whether ID actually reads rs1/rs2.
   assign LoadUseD = ctrl_q.valid && (ctrl_q.result_src == RES_LOAD) && (rd_q != '0) &&
                     ((rd_q == Rs1D) || (rd_q == Rs2D));

`ifdef EX_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (bubble_in) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end else begin
         bubble_cnt_d = bubble_cnt_q;
      end
   end

   // Bubble counter, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bubble_cnt_q <= 32'd0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign BubbleCntE = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized self-checking bench for id_ex_stage against a behavioural model of the EX slot.
// Define EX_BUBBLE_CNT_EN for both bench and RTL to exercise the bubble counter.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n, EnE, FlushE, ValidD;
   logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
   logic [4:0]  Rs1D, Rs2D, RdD;
   logic [3:0]  ALUControlD;
   logic        ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD;
   logic [1:0]  ResultSrcD;
   logic [31:0] ALUResultM, ResultW;
   logic [4:0]  RdM, RdW;
   logic        RegWriteM, RegWriteW;
   logic [31:0] SrcAE, SrcBE, WriteDataE, PCE, PCPlus4E, ImmExtE;
   logic [3:0]  ALUControlE;
   logic [4:0]  RdE, Rs1E, Rs2E;
   logic        RegWriteE, MemWriteE, BranchE, JumpE, ValidE, LoadUseD;
   logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
`ifdef EX_BUBBLE_CNT_EN
   logic [31:0] BubbleCntE;
`endif

   int total = 0;
   int bad   = 0;

   // Model of the instruction currently sitting in EX.
   logic        m_valid, m_rw, m_mw, m_br, m_jp, m_alusrc;
   logic [1:0]  m_rsrc;
   logic [3:0]  m_alu;
   logic [31:0] m_rd1, m_rd2, m_pc, m_pc4, m_imm, m_bub;
   logic [4:0]  m_rs1, m_rs2, m_rdx;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .EnE(EnE), .FlushE(FlushE), .ValidD(ValidD),
      .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
      .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD), .JumpD(JumpD),
      .ResultSrcD(ResultSrcD), .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
      .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
      .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE), .ALUControlE(ALUControlE),
      .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
      .ResultSrcE(ResultSrcE), .ValidE(ValidE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .LoadUseD(LoadUseD)
`ifdef EX_BUBBLE_CNT_EN
      , .BubbleCntE(BubbleCntE)
`endif
   );

   task automatic model_clear();
      {m_valid, m_rw, m_mw, m_br, m_jp, m_alusrc} = 6'b0;
      m_rsrc = 2'b00; m_alu = 4'h0;
      m_rd1 = 32'd0; m_rd2 = 32'd0; m_pc = 32'd0; m_pc4 = 32'd0; m_imm = 32'd0;
      m_rs1 = 5'd0; m_rs2 = 5'd0; m_rdx = 5'd0;
   endtask

   // One clock edge: update the model with what the edge should do, then settle.
   task automatic step();
      @(posedge clk);
      if (!rst_n) begin
         model_clear();
         m_bub = 32'd0;
      end else if (FlushE) begin
         model_clear();
         m_bub = m_bub + 32'd1;
      end else if (EnE) begin
         m_valid = ValidD; m_rw = RegWriteD; m_mw = MemWriteD; m_br = BranchD; m_jp = JumpD;
         m_alusrc = ALUSrcD; m_rsrc = ResultSrcD; m_alu = ALUControlD;
         m_rd1 = RD1D; m_rd2 = RD2D; m_pc = PCD; m_pc4 = PCPlus4D; m_imm = ImmExtD;
         m_rs1 = Rs1D; m_rs2 = Rs2D; m_rdx = RdD;
         if (!ValidD) m_bub = m_bub + 32'd1;
      end
      #1;
   endtask

   function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
      if (!m_valid) return 2'b00;
      if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b01;
      if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [31:0] fwd_val(input logic [1:0] sel, input logic [31:0] regv);
      if (sel == 2'b01) return ALUResultM;
      if (sel == 2'b10) return ResultW;
      return regv;
   endfunction

   task automatic drive_quiet();
      EnE = 1'b1; FlushE = 1'b0; ValidD = 1'b1;
      RD1D = 32'd0; RD2D = 32'd0; PCD = 32'd0; PCPlus4D = 32'd0; ImmExtD = 32'd0;
      Rs1D = 5'd0; Rs2D = 5'd0; RdD = 5'd0; ALUControlD = 4'h0; ALUSrcD = 1'b0;
      RegWriteD = 1'b0; MemWriteD = 1'b0; BranchD = 1'b0; JumpD = 1'b0; ResultSrcD = 2'b00;
      ALUResultM = 32'd0; RdM = 5'd0; RegWriteM = 1'b0;
      ResultW = 32'd0; RdW = 5'd0; RegWriteW = 1'b0;
   endtask

   task automatic drive_rand();
      EnE = ($urandom_range(0, 3) != 0); FlushE = ($urandom_range(0, 9) == 0);
      ValidD = ($urandom_range(0, 4) != 0);
      RD1D = $urandom; RD2D = $urandom; PCD = $urandom; PCPlus4D = $urandom; ImmExtD = $urandom;
      Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7)); RdD = 5'($urandom_range(0, 7));
      ALUControlD = 4'($urandom_range(0, 11)); ALUSrcD = 1'($urandom);
      RegWriteD = 1'($urandom); MemWriteD = 1'($urandom); BranchD = 1'($urandom); JumpD = 1'($urandom);
      ResultSrcD = 2'($urandom_range(0, 2));
      ALUResultM = $urandom; RdM = 5'($urandom_range(0, 7)); RegWriteM = 1'($urandom);
      ResultW = $urandom; RdW = 5'($urandom_range(0, 7)); RegWriteW = 1'($urandom);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_rand(); step();
      drive_rand(); step();
      total++;
      if ({SrcAE, SrcBE, WriteDataE, PCE, PCPlus4E, ImmExtE, ALUControlE, RdE, Rs1E, Rs2E,
           RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE, ValidE} !== '0) begin
         bad++; $display("FAIL reset_regs: got PCE=%h ValidE=%b SrcAE=%h, required all zero", PCE, ValidE, SrcAE);
      end
      total++;
      if ({ForwardAE, ForwardBE, LoadUseD} !== 5'b0) begin
         bad++; $display("FAIL reset_fwd: got fa=%b fb=%b lu=%b, required 0", ForwardAE, ForwardBE, LoadUseD);
      end
`ifdef EX_BUBBLE_CNT_EN
      total++;
      if (BubbleCntE !== 32'd0) begin
         bad++; $display("FAIL reset_cnt: got %0d, required 0", BubbleCntE);
      end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_pass_through();
      drive_quiet();
      RD1D = 32'd5; RD2D = 32'd7; Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd6;
      step();
      total++;
      if (SrcAE !== 32'd5 || SrcBE !== 32'd7) begin
         bad++; $display("FAIL pass_src: got A=%h B=%h, required 5/7", SrcAE, SrcBE);
      end
      total++;
      if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00 || ValidE !== 1'b1) begin
         bad++; $display("FAIL pass_fwd: got fa=%b fb=%b v=%b, required 00/00/1", ForwardAE, ForwardBE, ValidE);
      end
   endtask

   task automatic test_double_hazard();
      drive_quiet();
      Rs1D = 5'd3; RD1D = 32'h55;
      RdM = 5'd3; RdW = 5'd3; RegWriteM = 1'b1; RegWriteW = 1'b1;
      ALUResultM = 32'hAA; ResultW = 32'hBB;
      step();
      total++;
      if (SrcAE !== 32'hAA || ForwardAE !== 2'b01) begin
         bad++; $display("FAIL dbl_mem: got A=%h fa=%b, required aa/01", SrcAE, ForwardAE);
      end
      RegWriteM = 1'b0; #1;
      total++;
      if (SrcAE !== 32'hBB || ForwardAE !== 2'b10) begin
         bad++; $display("FAIL dbl_wb: got A=%h fa=%b, required bb/10", SrcAE, ForwardAE);
      end
      ValidD = 1'b0; RegWriteM = 1'b1;
      step();
      total++;
      if (SrcAE !== 32'h55 || ForwardAE !== 2'b00) begin
         bad++; $display("FAIL dbl_invalid: got A=%h fa=%b, required 55/00", SrcAE, ForwardAE);
      end
   endtask

   task automatic test_x0_imm();
      drive_quiet();
      Rs2D = 5'd0; RdM = 5'd0; RegWriteM = 1'b1; ALUResultM = 32'hDEAD; RD2D = 32'h99;
      step();
      total++;
      if (ForwardBE !== 2'b00 || SrcBE !== 32'h99) begin
         bad++; $display("FAIL x0_fwd: got fb=%b B=%h, required 00/99", ForwardBE, SrcBE);
      end
      ALUSrcD = 1'b1; ImmExtD = 32'h10; Rs2D = 5'd4; RdM = 5'd4; ALUResultM = 32'h1234;
      step();
      total++;
      if (SrcBE !== 32'h10 || WriteDataE !== 32'h1234 || ForwardBE !== 2'b01) begin
         bad++; $display("FAIL imm_src: got B=%h wd=%h fb=%b, required 10/1234/01", SrcBE, WriteDataE, ForwardBE);
      end
   endtask

   task automatic test_stall_flush();
      logic [31:0] cnt0;
      drive_quiet();
      PCD = 32'h100; RegWriteD = 1'b1; RdD = 5'd9;
      step();
      cnt0 = m_bub;
      for (int i = 0; i < 3; i++) begin
         drive_rand(); EnE = 1'b0; FlushE = 1'b0;
         step();
         total++;
         if (PCE !== 32'h100 || ValidE !== 1'b1 || RegWriteE !== 1'b1 || RdE !== 5'd9) begin
            bad++; $display("FAIL stall_hold%0d: got pc=%h v=%b rw=%b rd=%0d, required 100/1/1/9",
                            i, PCE, ValidE, RegWriteE, RdE);
         end
      end
      EnE = 1'b0; FlushE = 1'b1;
      step();
      total++;
      if (ValidE !== 1'b0 || RegWriteE !== 1'b0 || PCE !== 32'd0 || ALUControlE !== 4'h0) begin
         bad++; $display("FAIL flush_bubble: got v=%b rw=%b pc=%h alu=%h, required 0", ValidE, RegWriteE, PCE, ALUControlE);
      end
`ifdef EX_BUBBLE_CNT_EN
      total++;
      if (BubbleCntE !== cnt0 + 32'd1) begin
         bad++; $display("FAIL flush_cnt: got %0d, required %0d", BubbleCntE, cnt0 + 32'd1);
      end
`endif
   endtask

   task automatic test_load_use();
      drive_quiet();
      ResultSrcD = 2'b01; RdD = 5'd5; RegWriteD = 1'b1;
      step();
      Rs1D = 5'd1; Rs2D = 5'd5; #1;
      total++;
      if (LoadUseD !== 1'b1) begin
         bad++; $display("FAIL lu_rs2: got %b, required 1", LoadUseD);
      end
      Rs1D = 5'd5; Rs2D = 5'd2; #1;
      total++;
      if (LoadUseD !== 1'b1) begin
         bad++; $display("FAIL lu_rs1: got %b, required 1", LoadUseD);
      end
      Rs1D = 5'd0; Rs2D = 5'd0; RdD = 5'd0;
      step();
      total++;
      if (LoadUseD !== 1'b0) begin
         bad++; $display("FAIL lu_x0: got %b, required 0", LoadUseD);
      end
      ValidD = 1'b0; RdD = 5'd5; Rs2D = 5'd5;
      step();
      total++;
      if (LoadUseD !== 1'b0) begin
         bad++; $display("FAIL lu_invalid: got %b, required 0", LoadUseD);
      end
   endtask

   task automatic test_random(input int n);
      logic [1:0]  ea, eb;
      logic [31:0] ewd;
      logic        elu;
      for (int i = 0; i < n; i++) begin
         drive_rand();
         step();
         ea  = exp_fwd(m_rs1);
         eb  = exp_fwd(m_rs2);
         ewd = fwd_val(eb, m_rd2);
         elu = m_valid && m_rsrc == 2'b01 && m_rdx != 5'd0 && (m_rdx == Rs1D || m_rdx == Rs2D);
         total++;
         if ({PCE, PCPlus4E, ImmExtE, ALUControlE, RdE, Rs1E, Rs2E, RegWriteE, MemWriteE,
              BranchE, JumpE, ResultSrcE, ValidE} !==
             {m_pc, m_pc4, m_imm, m_alu, m_rdx, m_rs1, m_rs2, m_rw, m_mw, m_br, m_jp, m_rsrc, m_valid}) begin
            bad++; $display("FAIL rnd_regs[%0d]: got pc=%h v=%b rd=%0d, required pc=%h v=%b rd=%0d",
                            i, PCE, ValidE, RdE, m_pc, m_valid, m_rdx);
         end
         total++;
         if (ForwardAE !== ea || ForwardBE !== eb) begin
            bad++; $display("FAIL rnd_fwd[%0d]: got %b/%b, required %b/%b", i, ForwardAE, ForwardBE, ea, eb);
         end
         total++;
         if (SrcAE !== fwd_val(ea, m_rd1) || WriteDataE !== ewd || SrcBE !== (m_alusrc ? m_imm : ewd)) begin
            bad++; $display("FAIL rnd_data[%0d]: got A=%h B=%h wd=%h, required A=%h B=%h wd=%h", i, SrcAE, SrcBE,
                            WriteDataE, fwd_val(ea, m_rd1), (m_alusrc ? m_imm : ewd), ewd);
         end
         total++;
         if (LoadUseD !== elu) begin
            bad++; $display("FAIL rnd_lu[%0d]: got %b, required %b", i, LoadUseD, elu);
         end
`ifdef EX_BUBBLE_CNT_EN
         total++;
         if (BubbleCntE !== m_bub) begin
            bad++; $display("FAIL rnd_cnt[%0d]: got %0d, required %0d", i, BubbleCntE, m_bub);
         end
`endif
      end
   endtask

   initial begin
      rst_n = 1'b0;
      m_bub = 32'd0;
      model_clear();
      drive_quiet();
      @(negedge clk);
      test_reset();
      test_pass_through();
      test_double_hazard();
      test_x0_imm();
      test_stall_flush();
      test_load_use();
      test_random(400);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
